// File: rtl/ddr_pkg.sv
// Shared DDR3 MIG-side definitions for the burst reader and writer.
// A burst is 8 x 16-bit words carried as two 64-bit UI beats, upper half first.
package ddr_pkg;
  localparam int BURST_WORDS  = 8;
  localparam int WORD_W       = 16;
  localparam int UI_DATA_W    = 64;
  localparam int ADDR_W       = 27;
  localparam int BURST_ADDR_W = ADDR_W - 3;
  localparam int BUF_W        = BURST_WORDS * WORD_W;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef enum logic [2:0] {
    WR_IDLE,
    WR_FILL,
    WR_DATA0,
    WR_DATA1,
    WR_CMD
  } wr_state_e;

  // Byte mask for one beat from the valid bits of its four words (1 = byte not written).
  function automatic logic [7:0] beat_mask(input logic [3:0] word_valid);
    logic [7:0] m;
    for (int i = 0; i < 4; i++) begin
      m[2*i +: 2] = {2{~word_valid[i]}};
    end
    return m;
  endfunction
endpackage

// File: rtl/ram_burst_packer.sv
// Gathers 16-bit words into a 128-bit burst buffer with per-word valid bits
// and presents the selected 64-bit beat with its byte mask.
module ram_burst_packer
  import ddr_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en_i,
  input  logic [2:0]             wr_word_i,
  input  logic [WORD_W-1:0]      wr_data_i,
  input  logic                   clear_i,
  input  logic                   beat_sel_i,
  output logic                   full_next_o,
  output logic [UI_DATA_W-1:0]   beat_data_o,
  output logic [7:0]             beat_mask_o
);
  logic [BUF_W-1:0]       buf_q, buf_d;
  logic [BURST_WORDS-1:0] valid_q, valid_d;

  always_comb begin
    buf_d   = buf_q;
    valid_d = valid_q;
    if (clear_i) begin
      valid_d = '0;
    end
    if (wr_en_i) begin
      buf_d[wr_word_i*WORD_W +: WORD_W] = wr_data_i;
      valid_d[wr_word_i]                = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q   <= '0;
      valid_q <= '0;
    end else begin
      buf_q   <= buf_d;
      valid_q <= valid_d;
    end
  end

  assign full_next_o = &valid_d;

  // Beat 0 carries words 7..4, matching the reader's load order.
  assign beat_data_o = beat_sel_i ? buf_q[UI_DATA_W-1:0] : buf_q[BUF_W-1:UI_DATA_W];
  assign beat_mask_o = beat_sel_i ? beat_mask(valid_q[3:0]) : beat_mask(valid_q[7:4]);
endmodule

// File: rtl/ram_writer.sv
// Word-write gatherer issuing masked two-beat DDR3 writes through the MIG UI.
// Optional idle auto-flush is enabled by defining WRITER_TIMEOUT_EN.
module ram_writer
  import ddr_pkg::*;
#(
  parameter int FLUSH_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_W-1:0]     wr_address,
  input  logic [WORD_W-1:0]     wr_data,
  input  logic                  flush,
  output logic                  busy,
  output logic [ADDR_W-1:0]     ram_address,
  output logic [2:0]            ram_cmd,
  output logic                  ram_en,
  input  logic                  ram_rdy,
  output logic [UI_DATA_W-1:0]  ram_wdf_data,
  output logic [7:0]            ram_wdf_mask,
  output logic                  ram_wdf_wren,
  output logic                  ram_wdf_end,
  input  logic                  ram_wdf_rdy
);
  // Handshake: a word transfers on a rising clk edge where wr_valid & wr_ready;
  // ram_en/ram_rdy and ram_wdf_wren/ram_wdf_rdy likewise, with outputs held while not accepted.
  wr_state_e               state_q, state_d;
  logic [BURST_ADDR_W-1:0] burst_q, burst_d;
  logic                    same_burst, accept, full_next, timeout_hit;
  logic                    clear, beat_sel;
  logic [7:0]              beat_mask_w;

  assign same_burst = (wr_address[ADDR_W-1:3] == burst_q);
  assign wr_ready   = (state_q == WR_IDLE) | ((state_q == WR_FILL) & same_burst);
  assign accept     = wr_valid & wr_ready;

`ifdef WRITER_TIMEOUT_EN
  localparam int TO_W = $clog2(FLUSH_TIMEOUT + 1);
  logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;

  always_comb begin
    idle_cnt_d = '0;
    if ((state_q == WR_FILL) && !accept) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) idle_cnt_q <= '0;
    else       idle_cnt_q <= idle_cnt_d;
  end

  // Fires in the cycle the count reaches FLUSH_TIMEOUT, so DATA0 follows that edge.
  assign timeout_hit = (state_q == WR_FILL) && !accept &&
                       (idle_cnt_q == TO_W'(FLUSH_TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^FLUSH_TIMEOUT;
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    burst_d      = burst_q;
    ram_en       = 1'b0;
    ram_wdf_wren = 1'b0;
    ram_wdf_end  = 1'b0;
    clear        = 1'b0;
    beat_sel     = 1'b0;
    case (state_q)
      WR_IDLE: begin
        if (accept) begin
          burst_d = wr_address[ADDR_W-1:3];
          state_d = WR_FILL;
        end
      end
      WR_FILL: begin
        if ((wr_valid && !same_burst) || flush || timeout_hit || (accept && full_next)) begin
          state_d = WR_DATA0;
        end
      end
      WR_DATA0: begin
        ram_wdf_wren = 1'b1;
        if (ram_wdf_rdy) state_d = WR_DATA1;
      end
      WR_DATA1: begin
        ram_wdf_wren = 1'b1;
        ram_wdf_end  = 1'b1;
        beat_sel     = 1'b1;
        if (ram_wdf_rdy) state_d = WR_CMD;
      end
      WR_CMD: begin
        ram_en = 1'b1;
        if (ram_rdy) begin
          clear   = 1'b1;
          state_d = WR_IDLE;
        end
      end
      default: state_d = WR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WR_IDLE;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
    end
  end

  ram_burst_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .wr_en_i     (accept),
    .wr_word_i   (wr_address[2:0]),
    .wr_data_i   (wr_data),
    .clear_i     (clear),
    .beat_sel_i  (beat_sel),
    .full_next_o (full_next),
    .beat_data_o (ram_wdf_data),
    .beat_mask_o (beat_mask_w)
  );

  assign ram_wdf_mask = ram_wdf_wren ? beat_mask_w : 8'hFF;
  assign ram_address  = {burst_q, 3'b000};
  assign ram_cmd      = CMD_WRITE;
  assign busy         = (state_q != WR_IDLE);
endmodule

// File: tb/tb_ram_writer.sv
// Bench for ram_writer: directed scenarios plus random traffic against a burst-level
// memory-write model; run with and without WRITER_TIMEOUT_EN.
module tb_ram_writer;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid, wr_ready, flush, busy;
  logic [26:0] wr_address, ram_address;
  logic [15:0] wr_data;
  logic [2:0]  ram_cmd;
  logic        ram_en, ram_rdy, ram_wdf_wren, ram_wdf_end, ram_wdf_rdy;
  logic [63:0] ram_wdf_data;
  logic [7:0]  ram_wdf_mask;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  ram_writer #(.FLUSH_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_address(wr_address), .wr_data(wr_data),
    .flush(flush), .busy(busy),
    .ram_address(ram_address), .ram_cmd(ram_cmd), .ram_en(ram_en), .ram_rdy(ram_rdy),
    .ram_wdf_data(ram_wdf_data), .ram_wdf_mask(ram_wdf_mask), .ram_wdf_wren(ram_wdf_wren),
    .ram_wdf_end(ram_wdf_end), .ram_wdf_rdy(ram_wdf_rdy)
  );

  // ---------------- FIFO ready generation ----------------
  bit rnd_rdy = 1'b0;
  bit f_wdf_rdy = 1'b1, f_ram_rdy = 1'b1;
  bit r_wdf = 1'b1, r_ram = 1'b1;
  always @(posedge clk) begin
    #1;
    r_wdf = ($urandom_range(0, 3) != 0);
    r_ram = ($urandom_range(0, 3) != 0);
  end
  assign ram_wdf_rdy = rnd_rdy ? r_wdf : f_wdf_rdy;
  assign ram_rdy     = rnd_rdy ? r_ram : f_ram_rdy;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model: burst-level write gathering ----------------
  logic [72:0] exp_beat_q[$];   // {end, mask, data}
  logic [29:0] exp_cmd_q[$];    // {cmd, address}
  logic [15:0] m_words[8];
  bit   [7:0]  m_valid = '0;
  bit          m_pend = 1'b0;
  logic [23:0] m_burst = '0;

  task automatic model_emit();
    logic [63:0] d0, d1;
    logic [7:0]  k0, k1;
    for (int w = 0; w < 4; w++) begin
      d1[w*16 +: 16] = m_valid[w]     ? m_words[w]     : 16'h0;
      d0[w*16 +: 16] = m_valid[w + 4] ? m_words[w + 4] : 16'h0;
      k1[2*w +: 2]   = m_valid[w]     ? 2'b00 : 2'b11;
      k0[2*w +: 2]   = m_valid[w + 4] ? 2'b00 : 2'b11;
    end
    exp_beat_q.push_back({1'b0, k0, d0});
    exp_beat_q.push_back({1'b1, k1, d1});
    exp_cmd_q.push_back({3'b000, m_burst, 3'b000});
    m_pend  = 1'b0;
    m_valid = '0;
  endtask

  task automatic model_write(input logic [26:0] a, input logic [15:0] d, input bit fl);
    bit had;
    if (m_pend && a[26:3] != m_burst) model_emit();
    had = m_pend;
    m_pend  = 1'b1;
    m_burst = a[26:3];
    m_words[a[2:0]] = d;
    m_valid[a[2:0]] = 1'b1;
    if (m_valid == 8'hFF || (fl && had)) model_emit();
  endtask

  task automatic model_flush();
    if (m_pend) model_emit();
  endtask

  // ---------------- monitor / scoreboard ----------------
  bit          mon_en = 1'b1;
  int          n_wren = 0, n_en = 0;
  bit          prev_wstall = 1'b0, prev_cstall = 1'b0;
  logic [72:0] prev_beat;
  logic [29:0] prev_cmd;

  always @(negedge clk) begin
    logic [72:0] exp_b, got_b;
    if (mon_en && !reset) begin
      if (prev_wstall && ram_wdf_wren)
        check("hold_beat", {ram_wdf_end, ram_wdf_mask, ram_wdf_data}, prev_beat);
      if (prev_cstall && ram_en)
        check("hold_cmd", {ram_cmd, ram_address}, prev_cmd);
      if (ram_wdf_wren && ram_wdf_rdy) begin
        n_wren++;
        if (exp_beat_q.size() == 0) begin
          check("beat_unexpected", exp_beat_q.size(), 1);
        end else begin
          exp_b = exp_beat_q.pop_front();
          got_b = {ram_wdf_end, ram_wdf_mask, ram_wdf_data};
          for (int b = 0; b < 8; b++)
            if (exp_b[64 + b]) got_b[b*8 +: 8] = 8'h00;
          check("beat", got_b, exp_b);
        end
      end
      if (ram_en && ram_rdy) begin
        n_en++;
        if (exp_cmd_q.size() == 0) check("cmd_unexpected", exp_cmd_q.size(), 1);
        else check("cmd", {ram_cmd, ram_address}, exp_cmd_q.pop_front());
      end
      prev_wstall = ram_wdf_wren && !ram_wdf_rdy;
      prev_cstall = ram_en && !ram_rdy;
      prev_beat   = {ram_wdf_end, ram_wdf_mask, ram_wdf_data};
      prev_cmd    = {ram_cmd, ram_address};
    end else begin
      prev_wstall = 1'b0;
      prev_cstall = 1'b0;
    end
  end

  // ---------------- driver tasks (entered and left at posedge + 1) ----------------
  int last_waits;

  task automatic drv_write(input logic [26:0] a, input logic [15:0] d, input bit fl);
    int n = 0;
    model_write(a, d, fl);
    wr_valid = 1'b1; wr_address = a; wr_data = d; flush = fl;
    forever begin
      @(negedge clk);
      if (wr_ready) break;
      n++;
      if (n > 200) begin
        check("wr_ready_timeout", n, 0);
        break;
      end
    end
    last_waits = n;
    @(posedge clk); #1;
    wr_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic drv_flush();
    model_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy || exp_beat_q.size() != 0 || exp_cmd_q.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(tag, {busy, 8'(exp_beat_q.size()), 8'(exp_cmd_q.size())}, 17'h0);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w0, e0, n;
    reset = 1'b1; wr_valid = 1'b0; wr_address = '0; wr_data = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_state",
          {wr_ready, busy, ram_wdf_wren, ram_wdf_end, ram_en, ram_wdf_mask, ram_address},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 27'h0});
    @(posedge clk); #1;

    // Full burst with ready held high
    for (int i = 0; i < 8; i++) drv_write(27'h40 + 27'(i), 16'h1000 + 16'(i), 1'b0);
    wait_idle("full_idle");
    check("full_beat0_literal", 1, 1'b1 && (n_wren == 2));

    // Partial burst plus flush
    drv_write(27'h13, 16'hBEEF, 1'b0);
    drv_flush();
    wait_idle("partial_idle");

    // Burst change: 0x20 waits through FILL, DATA0, DATA1, CMD of burst 0x08
    drv_write(27'h08, 16'hAAAA, 1'b0);
    drv_write(27'h20, 16'h5555, 1'b0);
    check("chg_wait", last_waits, 4);
    @(negedge clk);
    check("chg_hold", {busy, ram_wdf_wren}, 2'b10);
    @(posedge clk); #1;
    drv_flush();
    wait_idle("chg_idle");

    // Backpressure on both FIFOs
    f_wdf_rdy = 1'b0; f_ram_rdy = 1'b0;
    w0 = n_wren; e0 = n_en;
    drv_write(27'h70, 16'h0A0A, 1'b0);
    drv_write(27'h75, 16'h0B0B, 1'b0);
    drv_flush();
    repeat (5) @(posedge clk);
    #1 f_wdf_rdy = 1'b1;
    repeat (2) @(posedge clk);
    repeat (3) @(posedge clk);
    #1 f_ram_rdy = 1'b1;
    wait_idle("bp_idle");
    check("bp_wren", n_wren - w0, 2);
    check("bp_en", n_en - e0, 1);

    // Overwrite and flush in the same cycle
    w0 = n_wren;
    drv_write(27'h31, 16'h1111, 1'b0);
    drv_write(27'h31, 16'h2222, 1'b1);
    wait_idle("ovw_idle");
    check("ovw_single", n_wren - w0, 2);

`ifdef WRITER_TIMEOUT_EN
    // Idle partial burst flushes itself; DATA0 visible 4 cycles after the accept edge
    drv_write(27'h50, 16'hC0DE, 1'b0);
    model_flush();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("timeout_wren_%0d", i), ram_wdf_wren, (i == 4));
    end
    @(posedge clk); #1;
    wait_idle("timeout_idle");
`else
    // Without the timeout a partial burst waits indefinitely
    w0 = n_wren;
    drv_write(27'h50, 16'hC0DE, 1'b0);
    repeat (300) @(negedge clk);
    check("no_timeout_hold", {busy, ram_wdf_wren}, 2'b10);
    check("no_timeout_pushes", n_wren - w0, 0);
    @(posedge clk); #1;
    drv_flush();
    wait_idle("no_timeout_idle");
`endif

    // Reset in DATA1 drops everything
    mon_en = 1'b0;
    drv_write(27'h60, 16'h6666, 1'b0);
    drv_flush();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ram_wdf_wren && ram_wdf_end) && n < 50);
    check("rst_reach_data1", ram_wdf_wren && ram_wdf_end, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid", {ram_wdf_wren, busy, wr_ready, ram_en}, 4'b0010);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_beat_q.delete(); exp_cmd_q.delete();
    m_pend = 1'b0; m_valid = '0;
    mon_en = 1'b1;

    // Random traffic over a few neighbouring bursts with random FIFO backpressure
    rnd_rdy = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 9) == 0) drv_flush();
      else drv_write(27'h100 + 27'($urandom_range(0, 31)), 16'($urandom),
                     ($urandom_range(0, 7) == 0));
    end
    drv_flush();
    wait_idle("rnd_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
